// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: decodes PS/2 set-2 make/break/E0/E1 byte streams, tracks held keys and
// queues shift-aware key events. Define PS2_KEY_TRACKER_REPEAT_EN to also queue typematic repeats.
module ps2_key_tracker #(
  parameter int N_KEYS     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           ps2_data,
  input  logic                 ps2_ready,
  input  logic                 ps2_overflow,
  output logic                 ps2_nextdata_n,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [18:0]          ev_data,
  output logic [3:0]           held_cnt,
  output logic [CNT_WIDTH-1:0] press_cnt,
  output logic                 tbl_full_err,
  output logic                 ev_drop
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EXT     = 3'd1;
  localparam logic [2:0] S_BRK     = 3'd2;
  localparam logic [2:0] S_EXT_BRK = 3'd3;
  localparam logic [2:0] S_SKIP    = 3'd4;

  logic                           nxt_n_q, nxt_n_d, consume;
  logic [7:0]                     byte_q, byte_d;
  logic                           bvld_q, bvld_d;
  logic [2:0]                     state_q, state_d, skip_q, skip_d;
  logic                           ev_gen, ev_rel, ev_ext, ev_rpt;
  logic [N_KEYS-1:0]              tv_q, tv_d, hit_vec, free_oh;
  logic [N_KEYS-1:0][8:0]         tk_q, tk_d;
  logic [8:0]                     key;
  logic                           hit, found;
  logic                           shl_q, shl_d, shr_q, shr_d;
  logic [CNT_WIDTH-1:0]           press_q, press_d;
  logic                           full_err_q, full_err_d, drop_q, drop_d;
  logic [7:0]                     ascii;
  logic [18:0]                    ev_word;
  logic                           push, pop, full, do_push;
  logic [AW-1:0]                  wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]                    cnt_q, cnt_d;
  logic [18:0]                    mem_q [FIFO_DEPTH];
  logic [3:0]                     held_c;

  function automatic logic [7:0] to_ascii(input logic [7:0] sc, input logic up);
    logic [7:0] a;
    a = 8'hFF;
    case (sc)
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
      8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
      8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
      8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
      8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
      8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
      default: a = 8'hFF;
    endcase
    if (up && a >= 8'h61 && a <= 8'h7A) a = a - 8'h20;
    return a;
  endfunction

  // Byte capture: one pop strobe per byte, so the next capture waits a cycle.
  always_comb begin
    consume = ps2_ready & nxt_n_q;
    nxt_n_d = ~consume;
    bvld_d  = consume;
    byte_d  = consume ? ps2_data : byte_q;
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    ev_gen  = 1'b0;
    ev_rel  = 1'b0;
    ev_ext  = 1'b0;
    if (ps2_overflow) begin
      state_d = S_IDLE;
    end else if (bvld_q) begin
      case (state_q)
        S_IDLE: begin
          if (byte_q == 8'hE0)      state_d = S_EXT;
          else if (byte_q == 8'hF0) state_d = S_BRK;
          else if (byte_q == 8'hE1) begin state_d = S_SKIP; skip_d = 3'd7; end
          else                      ev_gen = 1'b1;
        end
        S_EXT: begin
          if (byte_q == 8'hF0) state_d = S_EXT_BRK;
          else begin ev_gen = 1'b1; ev_ext = 1'b1; state_d = S_IDLE; end
        end
        S_BRK:     begin ev_gen = 1'b1; ev_rel = 1'b1; state_d = S_IDLE; end
        S_EXT_BRK: begin ev_gen = 1'b1; ev_rel = 1'b1; ev_ext = 1'b1; state_d = S_IDLE; end
        S_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Held table: match on {ext,scan}, new keys take the lowest free slot.
  always_comb begin
    key        = {ev_ext, byte_q};
    hit_vec    = '0;
    free_oh    = '0;
    found      = 1'b0;
    for (int i = 0; i < N_KEYS; i++) begin
      hit_vec[i] = tv_q[i] && (tk_q[i] == key);
      if (!tv_q[i] && !found) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
    hit        = |hit_vec;
    ev_rpt     = ev_gen & ~ev_rel & hit;
    tv_d       = tv_q;
    tk_d       = tk_q;
    press_d    = press_q;
    full_err_d = 1'b0;
    shl_d      = shl_q;
    shr_d      = shr_q;
    if (ev_gen) begin
      if (ev_rel) begin
        tv_d = tv_q & ~hit_vec;
      end else if (!hit) begin
        if (found) begin
          tv_d = tv_q | free_oh;
          for (int i = 0; i < N_KEYS; i++)
            if (free_oh[i]) tk_d[i] = key;
          if (press_q != '1) press_d = press_q + CNT_WIDTH'(1);
        end else begin
          full_err_d = 1'b1;
        end
      end
      if (!ev_ext && byte_q == 8'h12) shl_d = ~ev_rel;
      if (!ev_ext && byte_q == 8'h59) shr_d = ~ev_rel;
    end
  end

  // Shift flags are the registered values, i.e. before this byte's own update.
  always_comb begin
    ascii   = ev_ext ? 8'hFF : to_ascii(byte_q, shl_q | shr_q);
    ev_word = {ev_rel, ev_ext, ev_rpt, byte_q, ascii};
`ifdef PS2_KEY_TRACKER_REPEAT_EN
    push    = ev_gen;
`else
    push    = ev_gen & ~ev_rpt;
`endif
    pop     = ev_valid & ev_ready;
    full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
    do_push = push & (~full | pop);
    drop_d  = push & full & ~pop;
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    cnt_d   = cnt_q;
    if (do_push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (pop && !do_push) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_comb begin
    held_c = '0;
    for (int i = 0; i < N_KEYS; i++) held_c = held_c + {3'b000, tv_q[i]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nxt_n_q    <= 1'b1;
      byte_q     <= '0;
      bvld_q     <= 1'b0;
      state_q    <= S_IDLE;
      skip_q     <= '0;
      tv_q       <= '0;
      tk_q       <= '0;
      shl_q      <= 1'b0;
      shr_q      <= 1'b0;
      press_q    <= '0;
      full_err_q <= 1'b0;
      drop_q     <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      nxt_n_q    <= nxt_n_d;
      byte_q     <= byte_d;
      bvld_q     <= bvld_d;
      state_q    <= state_d;
      skip_q     <= skip_d;
      tv_q       <= tv_d;
      tk_q       <= tk_d;
      shl_q      <= shl_d;
      shr_q      <= shr_d;
      press_q    <= press_d;
      full_err_q <= full_err_d;
      drop_q     <= drop_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= ev_word;
  end

  assign ps2_nextdata_n = nxt_n_q;
  assign ev_valid       = (cnt_q != '0);
  assign ev_data        = ev_valid ? mem_q[rd_q] : '0;
  assign held_cnt       = held_c;
  assign press_cnt      = press_q;
  assign tbl_full_err   = full_err_q;
  assign ev_drop        = drop_q;
endmodule
